apb_timer_seq: RTL and testbench
================================

APB_TIMER_SEQ -- requirements
Module: apb_timer_seq

Interface
REQ-001 SHALL have: PCLK  in  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have: PRESETn  in  1  asynchronous active-low reset.
REQ-003 SHALL have: cfg_start  in  1  one-cycle request to program and start the timer.
REQ-004 SHALL have: cfg_stop  in  1  one-cycle request to stop the timer (CTRL := 0).
REQ-005 SHALL have: cfg_ctrl  in  32  CTRL word written last in a start sequence (e.g. 0x29 pulse, 0x37 pwm, 0x11 single).
REQ-006 SHALL have: cfg_val0 / cfg_val1  in  32 each  load values for channel 0 / channel 1.
REQ-007 SHALL have: cfg_busy  out  1  sequence in progress; cfg_done  out  1  one-cycle completion pulse; cfg_err  out  1  sticky error flag.
REQ-008 SHALL have APB master outputs PSEL, PENABLE, PWRITE (1 each), PADDR out 10 ([11:2]), PWDATA out 32, and inputs PRDATA 32, PREADY 1, PSLVERR 1.
REQ-009 SHALL have: TIMERINT  in  1  timer interrupt; irq_cnt  out  16  interrupts seen since last start.

Function
REQ-010 SHALL implement FSM states IDLE, SETUP, ACCESS, NEXT; only IDLE accepts requests.
REQ-011 Start sequence SHALL issue five APB writes in order: PADDR 1 <- val0, 2 <- val0, 3 <- val1, 4 <- val1, 0 <- ctrl.
REQ-012 Stop sequence SHALL issue one APB write: PADDR 0 <- 0.
REQ-013 cfg_* inputs SHALL be captured in IDLE on the accepting cycle; later changes have no effect on the running sequence.
REQ-014 SETUP: PSEL=1, PENABLE=0, PADDR/PWDATA/PWRITE valid; lasts exactly one cycle, then ACCESS.
REQ-015 ACCESS: PSEL=1, PENABLE=1, held until PREADY=1; transfer completes on that edge.
REQ-016 NEXT: one idle cycle (PSEL=0, PENABLE=0) between transfers; back-to-back SETUP forbidden.
REQ-017 Minimum start sequence with PREADY tied 1 SHALL be 15 cycles from accept to cfg_done.
REQ-018 cfg_stop and cfg_start asserted in the same IDLE cycle: stop SHALL win; start discarded.
REQ-019 Requests while cfg_busy=1 SHALL be ignored (not queued).
REQ-020 PSLVERR=1 with PREADY=1 SHALL abort remaining writes, set cfg_err, pulse cfg_done, return to IDLE.
REQ-021 cfg_err SHALL clear only on reset or an accepted cfg_start.
REQ-022 cfg_done SHALL pulse one cycle after the final transfer completes; cfg_busy deasserts the same cycle.
REQ-023 PADDR/PWDATA SHALL be 0 and PWRITE 0 whenever PSEL=0.
REQ-024 irq_cnt SHALL increment on each TIMERINT rising edge (registered edge detect), saturate at 0xFFFF, clear on accepted cfg_start.

Reset
REQ-025 On PRESETn=0: FSM=IDLE; PSEL, PENABLE, PWRITE, cfg_busy, cfg_done, cfg_err = 0; PADDR, PWDATA, irq_cnt = 0; TIMERINT edge register = 0.
REQ-026 Reset mid-transfer SHALL drop PSEL/PENABLE immediately (asynchronously); no resumption after release.
REQ-027 First request SHALL be accepted on the first rising edge after PRESETn deasserts.

Configuration
REQ-028 Macro APB_TIMER_SEQ_READBACK_EN defined: after the CTRL write of a start sequence, one APB read of PADDR 0 (PWRITE=0) SHALL be issued; PRDATA != captured ctrl sets cfg_err; cfg_done follows the read (minimum 18 cycles).
REQ-029 Macro undefined: no read issued; PRDATA ignored; PWRITE=1 on every transfer.

Verification
REQ-030 PREADY=1, start val0=9, val1=19, ctrl=0x29 -> writes (1,9),(2,9),(3,19),(4,19),(0,0x29); cfg_done at cycle 15; cfg_err=0.
REQ-031 PREADY low 3 cycles on the 3rd transfer -> PENABLE held 4 cycles on PADDR 3, sequence otherwise unchanged, done at cycle 18.
REQ-032 Start and stop same cycle in IDLE -> single write (0,0); start ignored; then start during busy -> ignored.
REQ-033 PSLVERR=1 on PADDR 2 write -> no writes to 3,4,0; cfg_err=1, cfg_done pulse; next start clears cfg_err.
REQ-034 TIMERINT toggled 5 times (5 rising edges) after start -> irq_cnt=5; PRESETn pulse mid-sequence -> all outputs 0, FSM IDLE.
REQ-035 READBACK_EN, PRDATA returns 0x37 for ctrl=0x37 -> cfg_err=0; returns 0x00 -> cfg_err=1.

Source files
------------

// File: rtl/apb_timer_seq.sv
// APB master that programs (start: five writes) or halts (stop: one write) a timer
// peripheral, and counts TIMERINT rising edges. Optional APB_TIMER_SEQ_READBACK_EN adds a CTRL read-back check.
module apb_timer_seq (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic        cfg_start,
  input  logic        cfg_stop,
  input  logic [31:0] cfg_ctrl,
  input  logic [31:0] cfg_val0,
  input  logic [31:0] cfg_val1,
  output logic        cfg_busy,
  output logic        cfg_done,
  output logic        cfg_err,
  output logic        PSEL,
  output logic        PENABLE,
  output logic        PWRITE,
  output logic [9:0]  PADDR,
  output logic [31:0] PWDATA,
  input  logic [31:0] PRDATA,
  input  logic        PREADY,
  input  logic        PSLVERR,
  input  logic        TIMERINT,
  output logic [15:0] irq_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_NEXT} state_e;

  state_e      state_q, state_d;
  logic [2:0]  idx_q, idx_d, last_idx_s;
  logic [31:0] val0_q, val0_d, val1_q, val1_d, ctrl_q, ctrl_d;
  logic        stop_q, stop_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [15:0] irq_q, irq_d;
  logic        tint_q;
  logic        psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
  logic [9:0]  paddr_q, paddr_d;
  logic [31:0] pwdata_q, pwdata_d;
  logic        rb_bad_s;

`ifdef APB_TIMER_SEQ_READBACK_EN
  // Index 5 is the CTRL read-back; stop sequences never read back.
  assign last_idx_s = stop_q ? 3'd4 : 3'd5;
  assign rb_bad_s   = (idx_q == 3'd5) && (PRDATA != ctrl_q);
`else
  logic unused_prdata_s;
  assign unused_prdata_s = ^PRDATA;
  assign last_idx_s      = 3'd4;
  assign rb_bad_s        = 1'b0;
`endif

  // Next-state, request capture and bus-phase decode
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    val0_d  = val0_q;
    val1_d  = val1_q;
    ctrl_d  = ctrl_q;
    stop_d  = stop_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;
    irq_d   = irq_q;
    if (TIMERINT && !tint_q && (irq_q != 16'hFFFF)) begin
      irq_d = irq_q + 16'd1;
    end else begin
      irq_d = irq_q;
    end

    case (state_q)
      S_IDLE: begin
        if (cfg_stop) begin
          // Stop outranks a simultaneous start: a single CTRL := 0 write.
          state_d = S_SETUP;
          idx_d   = 3'd4;
          ctrl_d  = 32'd0;
          stop_d  = 1'b1;
          busy_d  = 1'b1;
        end else if (cfg_start) begin
          state_d = S_SETUP;
          idx_d   = 3'd0;
          val0_d  = cfg_val0;
          val1_d  = cfg_val1;
          ctrl_d  = cfg_ctrl;
          stop_d  = 1'b0;
          busy_d  = 1'b1;
          err_d   = 1'b0;
          irq_d   = 16'd0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SETUP:  state_d = S_ACCESS;
      S_ACCESS: begin
        if (PREADY) begin
          if (PSLVERR || rb_bad_s) begin
            err_d = 1'b1;
          end else begin
            err_d = err_q;
          end
          if (PSLVERR || (idx_q == last_idx_s)) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = S_NEXT;
            idx_d   = idx_q + 3'd1;
          end
        end else begin
          state_d = S_ACCESS;
        end
      end
      S_NEXT:   state_d = S_SETUP;
      default:  state_d = S_IDLE;
    endcase

    psel_d    = (state_d == S_SETUP) || (state_d == S_ACCESS);
    penable_d = (state_d == S_ACCESS);
    paddr_d   = 10'd0;
    pwdata_d  = 32'd0;
    pwrite_d  = 1'b0;
    if (psel_d) begin
      pwrite_d = 1'b1;
      case (idx_d)
        3'd0:    begin paddr_d = 10'd1; pwdata_d = val0_d; end
        3'd1:    begin paddr_d = 10'd2; pwdata_d = val0_d; end
        3'd2:    begin paddr_d = 10'd3; pwdata_d = val1_d; end
        3'd3:    begin paddr_d = 10'd4; pwdata_d = val1_d; end
        3'd4:    begin paddr_d = 10'd0; pwdata_d = ctrl_d; end
        default: begin paddr_d = 10'd0; pwdata_d = 32'd0; pwrite_d = 1'b0; end
      endcase
    end else begin
      pwrite_d = 1'b0;
    end
  end

  // State and registered bus/status outputs
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q   <= S_IDLE;
      idx_q     <= 3'd0;
      val0_q    <= 32'd0;
      val1_q    <= 32'd0;
      ctrl_q    <= 32'd0;
      stop_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      irq_q     <= 16'd0;
      tint_q    <= 1'b0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= 10'd0;
      pwdata_q  <= 32'd0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      val0_q    <= val0_d;
      val1_q    <= val1_d;
      ctrl_q    <= ctrl_d;
      stop_q    <= stop_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      irq_q     <= irq_d;
      tint_q    <= TIMERINT;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
    end
  end

  assign PSEL     = psel_q;
  assign PENABLE  = penable_q;
  assign PWRITE   = pwrite_q;
  assign PADDR    = paddr_q;
  assign PWDATA   = pwdata_q;
  assign cfg_busy = busy_q;
  assign cfg_done = done_q;
  assign cfg_err  = err_q;
  assign irq_cnt  = irq_q;

endmodule

// File: tb/tb_apb_timer_seq.sv
// Directed bench for apb_timer_seq: bus-level transfer log, latency and status checks.
module tb_apb_timer_seq;

  logic        PCLK = 1'b0, PRESETn = 1'b0;
  logic        cfg_start = 1'b0, cfg_stop = 1'b0;
  logic [31:0] cfg_ctrl = 32'd0, cfg_val0 = 32'd0, cfg_val1 = 32'd0;
  logic        cfg_busy, cfg_done, cfg_err;
  logic        PSEL, PENABLE, PWRITE;
  logic [9:0]  PADDR;
  logic [31:0] PWDATA, PRDATA = 32'd0;
  logic        PREADY = 1'b1, PSLVERR = 1'b0, TIMERINT = 1'b0;
  logic [15:0] irq_cnt;

`ifdef APB_TIMER_SEQ_READBACK_EN
  localparam int RB = 1;
`else
  localparam int RB = 0;
`endif

  apb_timer_seq dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .cfg_start(cfg_start), .cfg_stop(cfg_stop),
    .cfg_ctrl(cfg_ctrl), .cfg_val0(cfg_val0), .cfg_val1(cfg_val1),
    .cfg_busy(cfg_busy), .cfg_done(cfg_done), .cfg_err(cfg_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR), .TIMERINT(TIMERINT),
    .irq_cnt(irq_cnt)
  );

  always #5 PCLK = ~PCLK;

  int vec_cnt = 0, err_cnt = 0;
  logic [9:0]  log_addr[8];
  logic [31:0] log_data[8];
  logic        log_wr[8];
  int          nlog, pen3, idle_viol = 0, n;

  task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  // Drives one request and runs until cfg_done; n = cycles from accept edge to done (0 on timeout).
  task automatic run_seq(input logic st, input logic sp, input logic [31:0] v0, input logic [31:0] v1,
                         input logic [31:0] ctl, input logic [31:0] rd, input int stall_addr,
                         input int stall_n, input int err_addr, input int poke_at, output int cyc);
    int stall_left;
    stall_left = stall_n;
    nlog = 0; pen3 = 0; cyc = 0;
    cfg_start = st; cfg_stop = sp; cfg_val0 = v0; cfg_val1 = v1; cfg_ctrl = ctl; PRDATA = rd;
    for (int i = 1; i <= 60; i++) begin
      if (i == 2) begin cfg_start = 1'b0; cfg_stop = 1'b0; end
      if (i == poke_at) begin
        cfg_start = 1'b1; cfg_val0 = 32'd77; cfg_val1 = 32'd78; cfg_ctrl = 32'hFF;
      end
      if (i == poke_at + 1) cfg_start = 1'b0;
      PREADY = 1'b1; PSLVERR = 1'b0;
      if (PSEL && PENABLE && (int'(PADDR) == stall_addr) && (stall_left > 0)) begin
        PREADY = 1'b0; stall_left--;
      end
      if (PSEL && PENABLE && (int'(PADDR) == err_addr)) PSLVERR = 1'b1;
      if (PSEL && PENABLE && (PADDR == 10'd3)) pen3++;
      if (PSEL && PENABLE && PREADY && (nlog < 8)) begin
        log_addr[nlog] = PADDR; log_data[nlog] = PWDATA; log_wr[nlog] = PWRITE; nlog++;
      end
      if (!PSEL && ((PADDR != 10'd0) || (PWDATA != 32'd0) || PWRITE)) idle_viol++;
      tick();
      if (cfg_done) begin cyc = i; break; end
    end
    PREADY = 1'b1; PSLVERR = 1'b0;
  endtask

  int exp_addr[5] = '{1, 2, 3, 4, 0};
  logic [31:0] exp_data[5];

  initial begin
    exp_data = '{32'd9, 32'd9, 32'd19, 32'd19, 32'h29};
    repeat (2) @(posedge PCLK);
    #1;
    check_vec("rst_psel", {31'd0, PSEL}, 32'd0);
    check_vec("rst_penable_pwrite", {30'd0, PENABLE, PWRITE}, 32'd0);
    check_vec("rst_paddr_pwdata", {22'd0, PADDR} | PWDATA, 32'd0);
    check_vec("rst_status", {29'd0, cfg_busy, cfg_done, cfg_err}, 32'd0);
    check_vec("rst_irq", {16'd0, irq_cnt}, 32'd0);
    PRESETn = 1'b1;

    // Basic start, accepted on the first edge after reset release
    run_seq(1'b1, 1'b0, 32'd9, 32'd19, 32'h29, 32'h29, 99, 0, 99, 100, n);
    check_vec("start_cycles", n, RB ? 32'd18 : 32'd15);
    check_vec("start_nlog", nlog, RB ? 32'd6 : 32'd5);
    for (int k = 0; k < 5; k++) begin
      check_vec($sformatf("start_addr%0d", k), {22'd0, log_addr[k]}, exp_addr[k]);
      check_vec($sformatf("start_data%0d", k), log_data[k], exp_data[k]);
      check_vec($sformatf("start_wr%0d", k), {31'd0, log_wr[k]}, 32'd1);
    end
    check_vec("start_err", {31'd0, cfg_err}, 32'd0);
    check_vec("start_busy_at_done", {31'd0, cfg_busy}, 32'd0);
    tick();
    check_vec("done_one_cycle", {31'd0, cfg_done}, 32'd0);

    // PREADY low for 3 cycles on the third transfer
    run_seq(1'b1, 1'b0, 32'd9, 32'd19, 32'h29, 32'h29, 3, 3, 99, 100, n);
    check_vec("stall_cycles", n, RB ? 32'd21 : 32'd18);
    check_vec("stall_penable_len", pen3, 32'd4);
    check_vec("stall_nlog", nlog, RB ? 32'd6 : 32'd5);
    check_vec("stall_addr2", {22'd0, log_addr[2]}, 32'd3);
    check_vec("stall_data2", log_data[2], 32'd19);
    tick();

    // Start and stop together: stop wins
    run_seq(1'b1, 1'b1, 32'd5, 32'd6, 32'h37, 32'd0, 99, 0, 99, 100, n);
    check_vec("stop_cycles", n, 32'd3);
    check_vec("stop_nlog", nlog, 32'd1);
    check_vec("stop_write", {log_wr[0], 21'd0, log_addr[0]} | log_data[0], 32'h8000_0000);
    tick();

    // Start pulsed again while busy with different values: ignored, captured values kept
    run_seq(1'b1, 1'b0, 32'd9, 32'd19, 32'h29, 32'h29, 99, 0, 99, 4, n);
    check_vec("busy_req_cycles", n, RB ? 32'd18 : 32'd15);
    check_vec("busy_req_nlog", nlog, RB ? 32'd6 : 32'd5);
    check_vec("busy_req_data1", log_data[1], 32'd9);
    check_vec("busy_req_data3", log_data[3], 32'd19);
    check_vec("busy_req_ctrl", log_data[4], 32'h29);
    tick();
    check_vec("busy_req_not_queued", {30'd0, cfg_busy, PSEL}, 32'd0);

    // PSLVERR on the PADDR 2 write aborts the rest
    run_seq(1'b1, 1'b0, 32'd9, 32'd19, 32'h29, 32'h29, 99, 0, 2, 100, n);
    check_vec("slverr_cycles", n, 32'd6);
    check_vec("slverr_nlog", nlog, 32'd2);
    check_vec("slverr_last_addr", {22'd0, log_addr[1]}, 32'd2);
    check_vec("slverr_err", {31'd0, cfg_err}, 32'd1);
    tick();
    check_vec("slverr_idle", {30'd0, cfg_busy, PSEL}, 32'd0);
    run_seq(1'b0, 1'b1, 32'd0, 32'd0, 32'd0, 32'd0, 99, 0, 99, 100, n);
    check_vec("err_sticky_over_stop", {31'd0, cfg_err}, 32'd1);
    tick();
    run_seq(1'b1, 1'b0, 32'd1, 32'd2, 32'h11, 32'h11, 99, 0, 99, 100, n);
    check_vec("err_cleared_by_start", {31'd0, cfg_err}, 32'd0);

    // Five TIMERINT rising edges
    for (int k = 0; k < 5; k++) begin
      TIMERINT = 1'b1; tick(); tick();
      TIMERINT = 1'b0; tick();
    end
    tick();
    check_vec("irq_cnt5", {16'd0, irq_cnt}, 32'd5);
    run_seq(1'b1, 1'b0, 32'd1, 32'd2, 32'h11, 32'h11, 99, 0, 99, 100, n);
    check_vec("irq_cleared_by_start", {16'd0, irq_cnt}, 32'd0);
    tick();

`ifdef APB_TIMER_SEQ_READBACK_EN
    run_seq(1'b1, 1'b0, 32'd3, 32'd4, 32'h37, 32'h37, 99, 0, 99, 100, n);
    check_vec("rb_ok_err", {31'd0, cfg_err}, 32'd0);
    check_vec("rb_read_addr", {log_wr[5], 21'd0, log_addr[5]}, 32'd0);
    tick();
    run_seq(1'b1, 1'b0, 32'd3, 32'd4, 32'h37, 32'h00, 99, 0, 99, 100, n);
    check_vec("rb_bad_err", {31'd0, cfg_err}, 32'd1);
    check_vec("rb_bad_cycles", n, 32'd18);
    tick();
`else
    run_seq(1'b1, 1'b0, 32'd3, 32'd4, 32'h37, 32'h00, 99, 0, 99, 100, n);
    check_vec("prdata_ignored_err", {31'd0, cfg_err}, 32'd0);
    check_vec("prdata_ignored_ctrl_wr", {log_wr[4], 31'd0} | log_data[4], 32'h8000_0037);
    tick();
`endif

    // Asynchronous reset mid-sequence
    cfg_start = 1'b1; cfg_val0 = 32'd9; cfg_val1 = 32'd19; cfg_ctrl = 32'h29;
    tick();
    cfg_start = 1'b0;
    tick(); tick(); tick();
    check_vec("pre_rst_psel", {31'd0, PSEL}, 32'd1);
    #2 PRESETn = 1'b0;
    #1;
    check_vec("midrst_bus", {29'd0, PSEL, PENABLE, PWRITE}, 32'd0);
    check_vec("midrst_addr_data", {22'd0, PADDR} | PWDATA, 32'd0);
    check_vec("midrst_status", {29'd0, cfg_busy, cfg_done, cfg_err}, 32'd0);
    tick();
    PRESETn = 1'b1;
    tick(); tick(); tick();
    check_vec("no_resume", {30'd0, PSEL, cfg_busy}, 32'd0);
    run_seq(1'b1, 1'b0, 32'd9, 32'd19, 32'h29, 32'h29, 99, 0, 99, 100, n);
    check_vec("post_rst_cycles", n, RB ? 32'd18 : 32'd15);

    check_vec("idle_bus_zero", idle_viol, 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
